alu_seq: RTL and testbench

- Parametrised, handshaked successor to the core's combinational ALU.
- Keeps the same 6-bit operation encoding and result semantics, generalised to XLEN bits.
- Single-cycle ops return one cycle after acceptance.
- DIV/DIVU/REM/REMU run on an iterative restoring divider with RISC-V divide-by-zero and overflow results.
- Sits between the execute-stage issue logic and writeback; stalls issue via in_ready.

---
 rtl/alu_pkg.sv | 46 ++++
 rtl/serial_divider.sv | 78 +++++++
 rtl/alu_seq.sv | 206 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   - 6-bit operation codes (same encoding as the combinational core ALU)
//   - is_div(): true for DIV/DIVU/REM/REMU
//   - state_t: handshake/divider FSM states
package alu_pkg;

  localparam logic [5:0] ALU_AND    = 6'b000000;
  localparam logic [5:0] ALU_OR     = 6'b000001;
  localparam logic [5:0] ALU_ADD    = 6'b000010;
  localparam logic [5:0] ALU_SLL    = 6'b000011;
  localparam logic [5:0] ALU_SRL    = 6'b000100;
  localparam logic [5:0] ALU_XOR    = 6'b000101;
  localparam logic [5:0] ALU_SUB    = 6'b000110;
  localparam logic [5:0] ALU_SRA    = 6'b000111;
  localparam logic [5:0] ALU_BEQ    = 6'b001000;
  localparam logic [5:0] ALU_BNE    = 6'b001001;
  localparam logic [5:0] ALU_BLT    = 6'b001010;
  localparam logic [5:0] ALU_BGE    = 6'b001011;
  localparam logic [5:0] ALU_BLTU   = 6'b001100;
  localparam logic [5:0] ALU_BGEU   = 6'b001101;
  localparam logic [5:0] ALU_MUL    = 6'b010000;
  localparam logic [5:0] ALU_MULH   = 6'b010001;
  localparam logic [5:0] ALU_MULHSU = 6'b010010;
  localparam logic [5:0] ALU_MULHU  = 6'b010011;
  localparam logic [5:0] ALU_DIV    = 6'b010100;
  localparam logic [5:0] ALU_DIVU   = 6'b010101;
  localparam logic [5:0] ALU_REM    = 6'b010110;
  localparam logic [5:0] ALU_REMU   = 6'b010111;
  localparam logic [5:0] ALU_MIN    = 6'b100000;
  localparam logic [5:0] ALU_MAX    = 6'b100001;
  localparam logic [5:0] ALU_MINU   = 6'b100010;
  localparam logic [5:0] ALU_MAXU   = 6'b100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // The four divide ops share the 0101xx prefix.
  function automatic logic is_div(input logic [5:0] op);
    return op[5:2] == 4'b0101;
  endfunction

endpackage

// File: rtl/serial_divider.sv
// serial_divider: unsigned restoring divider, one quotient bit per cycle,
// MSB first.
//   clk, rst_n      clock, async active-low reset
//   start           load dividend/divisor and begin (count restarts at 0)
//   abort           drop any division in progress
//   dividend        unsigned dividend, sampled on start
//   divisor         unsigned divisor (non-zero), sampled on start
//   done            high during the last iteration cycle; quotient and
//                   remainder hold the final values from the next cycle on
//   quotient        quotient register
//   remainder       partial/final remainder register
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  logic [CW-1:0]   count;
  logic            active;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] div_q;
  logic [XLEN:0]   shifted;
  logic [XLEN:0]   diff;

  // Bring down the next dividend bit; the trial subtraction's borrow bit
  // decides whether the subtraction is kept (restoring scheme).
  assign shifted = {rem_q, quo_q[XLEN-1]};
  assign diff    = shifted - {1'b0, div_q};

  assign done      = active && (count == LAST);
  assign quotient  = quo_q;
  assign remainder = rem_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      active <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
    end else if (abort) begin
      count  <= '0;
      active <= 1'b0;
    end else if (start) begin
      quo_q  <= dividend;
      rem_q  <= '0;
      div_q  <= divisor;
      count  <= '0;
      active <= 1'b1;
    end else if (active) begin
      if (!diff[XLEN]) begin
        rem_q <= diff[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b1};
      end else begin
        rem_q <= shifted[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], 1'b0};
      end
      // Wraps back to 0 on the last iteration.
      count <= count + 1'b1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked, XLEN-wide ALU. Single-cycle ops answer one cycle
// after acceptance; DIV/DIVU/REM/REMU use serial_divider (XLEN+2 cycles).
//   clk, rst_n      clock, async active-low reset
//   flush           synchronous abort: back to IDLE, no accept this cycle
//   in_valid/in_ready, alu_op, operand1, operand2   request side
//   out_valid/out_ready, result, zero               response side
//   busy            FSM not in IDLE
//   dbg_state       current FSM state (state_t encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// The request side must hold alu_op/operands while in_valid && !in_ready;
// result/zero are stable while out_valid && !out_ready. in_ready is high in
// IDLE, and in DONE when the held result is being taken the same cycle, so
// single-cycle ops stream with no bubble.
//
// XLEN must be >= 8 and a power of two.
module alu_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      alu_op,
  input  logic [XLEN-1:0] operand1,
  input  logic [XLEN-1:0] operand2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic [1:0]      dbg_state
);

  localparam int SHW = $clog2(XLEN);

  state_t state, next_state;

  logic            accept;
  logic            div_path;
  logic            signed_div;
  logic            div_start;
  logic            div_done;
  logic [XLEN-1:0] div_quo;
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            neg_q;
  logic            neg_r;
  logic            is_rem;
  logic [XLEN-1:0] fix_val;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] result_q;
  logic            zero_q;

  logic [SHW-1:0]    shamt;
  logic              slt;
  logic              sltu;
  logic              ext_a;
  logic              ext_b;
  logic [2*XLEN-1:0] prod;

  // ---------------- handshake ----------------
  assign in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state == ST_DONE);
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;
  assign result    = result_q;
  assign zero      = zero_q;

  // Divide by zero is answered immediately from alu_res; only a real
  // division goes through the iterative path.
  assign div_path   = is_div(alu_op) && (operand2 != '0);
  assign signed_div = (alu_op == ALU_DIV) || (alu_op == ALU_REM);
  assign div_start  = accept && div_path;

  assign abs_a = (signed_div && operand1[XLEN-1]) ? ('0 - operand1) : operand1;
  assign abs_b = (signed_div && operand2[XLEN-1]) ? ('0 - operand2) : operand2;

  serial_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .abort     (flush),
    .dividend  (abs_a),
    .divisor   (abs_b),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // MIN / -1 needs no special case: |MIN| is 2^(XLEN-1) as an unsigned
  // magnitude, the quotient magnitude is that same pattern, both signs are
  // negative so it is not negated, and the remainder is 0.
  assign fix_val = is_rem ? (neg_r ? ('0 - div_rem) : div_rem)
                          : (neg_q ? ('0 - div_quo) : div_quo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      is_rem <= 1'b0;
    end else if (div_start) begin
      neg_q  <= signed_div && (operand1[XLEN-1] ^ operand2[XLEN-1]);
      neg_r  <= signed_div && operand1[XLEN-1];
      is_rem <= alu_op[1];
    end
  end

  // ---------------- single-cycle datapath ----------------
  assign shamt = operand2[SHW-1:0];
  assign slt   = $signed(operand1) < $signed(operand2);
  assign sltu  = operand1 < operand2;

  // One multiplier serves all four MUL ops; only the operand extension
  // differs, and the low half is the same for every extension.
  assign ext_a = operand1[XLEN-1] && ((alu_op == ALU_MULH) || (alu_op == ALU_MULHSU));
  assign ext_b = operand2[XLEN-1] && (alu_op == ALU_MULH);
  assign prod  = {{XLEN{ext_a}}, operand1} * {{XLEN{ext_b}}, operand2};

  always_comb begin
    alu_res = operand2;
    case (alu_op)
      ALU_ADD:    alu_res = operand1 + operand2;
      ALU_SUB:    alu_res = operand1 - operand2;
      ALU_AND:    alu_res = operand1 & operand2;
      ALU_OR:     alu_res = operand1 | operand2;
      ALU_XOR:    alu_res = operand1 ^ operand2;
      ALU_SLL:    alu_res = operand1 << shamt;
      ALU_SRL:    alu_res = operand1 >> shamt;
      ALU_SRA:    alu_res = $unsigned($signed(operand1) >>> shamt);
      // Compares return 0 when the condition holds, 1 otherwise.
      ALU_BEQ:    alu_res = {{(XLEN-1){1'b0}}, !(operand1 == operand2)};
      ALU_BNE:    alu_res = {{(XLEN-1){1'b0}}, !(operand1 != operand2)};
      ALU_BLT:    alu_res = {{(XLEN-1){1'b0}}, !slt};
      ALU_BGE:    alu_res = {{(XLEN-1){1'b0}}, slt};
      ALU_BLTU:   alu_res = {{(XLEN-1){1'b0}}, !sltu};
      ALU_BGEU:   alu_res = {{(XLEN-1){1'b0}}, sltu};
      ALU_MUL:    alu_res = prod[XLEN-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  alu_res = prod[2*XLEN-1:XLEN];
      // Only reached for a zero divisor.
      ALU_DIV,
      ALU_DIVU:   alu_res = '1;
      ALU_REM,
      ALU_REMU:   alu_res = operand1;
      ALU_MIN:    alu_res = slt  ? operand1 : operand2;
      ALU_MAX:    alu_res = slt  ? operand2 : operand1;
      ALU_MINU:   alu_res = sltu ? operand1 : operand2;
      ALU_MAXU:   alu_res = sltu ? operand2 : operand1;
      default:    alu_res = operand2;
    endcase
  end

  // ---------------- result register ----------------
  // Flush leaves result/zero at their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
    end else if (!flush) begin
      if (accept && !div_path) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
      end else if (state == ST_FIX) begin
        result_q <= fix_val;
        zero_q   <= (fix_val == '0);
      end
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (flush) begin
      next_state = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (accept) next_state = div_path ? ST_DIV : ST_DONE;
        ST_DIV:  if (div_done) next_state = ST_FIX;
        ST_FIX:  next_state = ST_DONE;
        ST_DONE: begin
          if (out_ready) begin
            if (accept) next_state = div_path ? ST_DIV : ST_DONE;
            else        next_state = ST_IDLE;
          end
        end
        default: next_state = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;

  // ---------------- clock / reset ----------------
  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [5:0]      alu_op = '0;
  logic [XLEN-1:0] operand1 = '0;
  logic [XLEN-1:0] operand2 = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            busy;
  logic [1:0]      dbg_state;

  always #5 clk = ~clk;

  alu_seq #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .operand1  (operand1),
    .operand2  (operand2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int              n_checks = 0;
  int              n_fail = 0;
  logic [XLEN-1:0] exp_q[$];
  logic [XLEN-1:0] mon_exp;
  bit              rand_bp = 1'b0;

  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: RISC-V style semantics from plain integer arithmetic.
  function automatic logic [XLEN-1:0] ref_alu(input logic [5:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    int                sa, sb;
    longint            ps;
    longint unsigned   pu;
    logic [XLEN-1:0]   r;
    sa = a;
    sb = b;
    r  = b;
    case (op)
      ALU_ADD:    r = a + b;
      ALU_SUB:    r = a - b;
      ALU_AND:    r = a & b;
      ALU_OR:     r = a | b;
      ALU_XOR:    r = a ^ b;
      ALU_SLL:    r = a << b[4:0];
      ALU_SRL:    r = a >> b[4:0];
      ALU_SRA:    r = sa >>> b[4:0];
      ALU_BEQ:    r = (a == b) ? 0 : 1;
      ALU_BNE:    r = (a != b) ? 0 : 1;
      ALU_BLT:    r = (sa < sb) ? 0 : 1;
      ALU_BGE:    r = (sa >= sb) ? 0 : 1;
      ALU_BLTU:   r = (a < b) ? 0 : 1;
      ALU_BGEU:   r = (a >= b) ? 0 : 1;
      ALU_MUL:    r = a * b;
      ALU_MULH:   begin ps = longint'(sa) * longint'(sb); r = ps[63:32]; end
      ALU_MULHSU: begin ps = longint'(sa) * longint'(b);  r = ps[63:32]; end
      ALU_MULHU:  begin pu = {32'b0, a} * {32'b0, b};      r = pu[63:32]; end
      ALU_DIV: begin
        if (b == 0) r = '1;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = sa / sb;
      end
      ALU_DIVU:   r = (b == 0) ? '1 : a / b;
      ALU_REM: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else r = sa % sb;
      end
      ALU_REMU:   r = (b == 0) ? a : a % b;
      ALU_MIN:    r = (sa < sb) ? a : b;
      ALU_MAX:    r = (sa < sb) ? b : a;
      ALU_MINU:   r = (a < b) ? a : b;
      ALU_MAXU:   r = (a < b) ? b : a;
      default:    r = b;
    endcase
    return r;
  endfunction

  // Every taken result is compared in order against the expected queue.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", result, mon_exp);
        check("zero", 32'(zero), 32'(mon_exp == '0));
      end
    end
  end

  // Random backpressure during the random phase.
  always @(posedge clk) begin
    #1;
    if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accept edge.
  task automatic send(input logic [5:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input bit expect_out);
    int guard;
    in_valid = 1'b1;
    alu_op   = op;
    operand1 = a;
    operand2 = b;
    if (expect_out) exp_q.push_back(ref_alu(op, a, b));
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic op_lat(input string tag, input logic [5:0] op, input logic [XLEN-1:0] a,
                        input logic [XLEN-1:0] b, input int exp_lat, input logic [XLEN-1:0] exp_val);
    int lat;
    step();
    send(op, a, b, 1'b1);
    wait_out(lat);
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_val"}, result, exp_val);
  endtask

  function automatic logic [XLEN-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom();
    endcase
  endfunction

  logic [5:0] op_tab[28] = '{ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
                             ALU_BEQ, ALU_BNE, ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU,
                             ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
                             ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU,
                             ALU_MIN, ALU_MAX, ALU_MINU, ALU_MAXU, 6'b111111, 6'b011000};

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int guard;
    logic any_valid;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst_n = 1'b1;

    // ADD then back-to-back SUB accepted in ADD's DONE cycle.
    step();
    send(ALU_ADD, 32'd7, 32'd5, 1'b1);
    check("add_lat1", 32'(out_valid), 32'd1);
    check("add_val", result, 32'd12);
    check("add_zero", 32'(zero), 32'd0);
    send(ALU_SUB, 32'd5, 32'd5, 1'b1);
    check("sub_lat1", 32'(out_valid), 32'd1);
    check("sub_val", result, 32'd0);
    check("sub_zero", 32'(zero), 32'd1);

    // Division and arithmetic corner cases.
    op_lat("div_neg",   ALU_DIV,    32'hFFFF_FFEC, 32'd3,         34, 32'hFFFF_FFFA);
    op_lat("rem_neg",   ALU_REM,    32'hFFFF_FFEC, 32'd3,         34, 32'hFFFF_FFFE);
    op_lat("divu_big",  ALU_DIVU,   32'hFFFF_FFEC, 32'd3,         34, 32'h5555_554E);
    op_lat("div_ovf",   ALU_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h8000_0000);
    op_lat("rem_ovf",   ALU_REM,    32'h8000_0000, 32'hFFFF_FFFF, 34, 32'd0);
    op_lat("divu_zero", ALU_DIVU,   32'd9,         32'd0,         1,  32'hFFFF_FFFF);
    op_lat("remu_zero", ALU_REMU,   32'd9,         32'd0,         1,  32'd9);
    op_lat("rem_zero",  ALU_REM,    32'hFFFF_FFF9, 32'd0,         1,  32'hFFFF_FFF9);
    op_lat("mulh",      ALU_MULH,   32'h8000_0000, 32'd2,         1,  32'hFFFF_FFFF);
    op_lat("mulhu",     ALU_MULHU,  32'h8000_0000, 32'd2,         1,  32'd1);
    op_lat("mulhsu",    ALU_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1,  32'hFFFF_FFFF);
    op_lat("mul",       ALU_MUL,    32'h0001_0000, 32'h0001_0001, 1,  32'h0001_0000);
    op_lat("sra",       ALU_SRA,    32'h8000_0000, 32'h0000_0021, 1,  32'hC000_0000);
    op_lat("blt",       ALU_BLT,    32'hFFFF_FFFF, 32'd1,         1,  32'd0);
    op_lat("bltu",      ALU_BLTU,   32'hFFFF_FFFF, 32'd1,         1,  32'd1);
    op_lat("min",       ALU_MIN,    32'hFFFF_FFFF, 32'd1,         1,  32'hFFFF_FFFF);
    op_lat("maxu",      ALU_MAXU,   32'hFFFF_FFFF, 32'd1,         1,  32'hFFFF_FFFF);
    op_lat("unknown",   6'b111111,  32'd3,         32'h1234_5678, 1,  32'h1234_5678);

    // Backpressure on a completed division.
    step();
    out_ready = 1'b0;
    send(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1);
    wait_out(lat);
    check("bp_lat", lat, 34);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_hold", result, 32'hFFFF_FFF2);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_taken_valid", 32'(out_valid), 32'd0);
    check("bp_taken_q", exp_q.size(), 0);

    // Flush at cycle 10 of a division.
    step();
    send(ALU_DIV, 32'd1000, 32'd7, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_state", 32'(dbg_state), 32'd0);
    any_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_valid |= out_valid;
    end
    check("flush_quiet", 32'(any_valid), 32'd0);
    step();
    send(ALU_ADD, 32'd1, 32'd1, 1'b1);
    @(negedge clk);
    check("flush_add", result, 32'd2);

    // Flush in IDLE suppresses an accept.
    step();
    in_valid = 1'b1;
    alu_op   = ALU_ADD;
    operand1 = 32'd3;
    operand2 = 32'd4;
    flush    = 1'b1;
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    @(negedge clk);
    check("flush_idle_valid", 32'(out_valid), 32'd0);
    check("flush_idle_keep", result, 32'd2);

    // Flush drops a held result.
    step();
    out_ready = 1'b0;
    send(ALU_ADD, 32'd9, 32'd9, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_done_valid", 32'(out_valid), 32'd0);
    check("flush_done_keep", result, 32'd18);

    // Asynchronous reset in the middle of a division.
    step();
    send(ALU_DIV, 32'd5000, 32'd3, 1'b0);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_result", result, 32'd0);
    step();
    rst_n = 1'b1;
    any_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      any_valid |= out_valid;
    end
    check("arst_quiet", 32'(any_valid), 32'd0);
    step();
    send(ALU_ADD, 32'd20, 32'hFFFF_FFFF, 1'b1);

    // Random ops with random backpressure and operand scrambling.
    step();
    rand_bp = 1'b1;
    for (int n = 0; n < 250; n++) begin
      send(op_tab[$urandom_range(0, 27)], rand_operand(), rand_operand(), 1'b1);
      operand1 = $urandom();
      operand2 = $urandom();
      alu_op   = op_tab[$urandom_range(0, 27)];
      repeat ($urandom_range(0, 1)) step();
    end
    @(negedge clk);
    rand_bp   = 1'b0;
    out_ready = 1'b1;

    guard = 0;
    while (exp_q.size() != 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check("drain", exp_q.size(), 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
